pulse_stretcher: RTL and testbench

Converts single-cycle trigger pulses into level pulses of programmable width, with a programmable guard gap between consecutive pulses. It is the pulse-to-level counterpart of the edge detector: it sits at the transmit side of an event path, and its output is consumed by logic that samples levels or re-extracts edges. Each output pulse is always followed by at least one low cycle, so a downstream edge detector sees every pulse as a distinct rise/fall pair.

---
 rtl/pulse_stretcher.sv | 106 ++++++++++
 tb/tb_pulse_stretcher.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into level pulses of programmable width,
// followed by a programmable guard gap. All outputs are registered.
module pulse_stretcher #(
    parameter int unsigned CNT_WIDTH = 8,
    parameter bit          RETRIGGER = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 TRIG_IN,
    input  logic [CNT_WIDTH-1:0] LENGTH_IN,
    input  logic [CNT_WIDTH-1:0] GAP_IN,
    output logic                 LEVEL_OUT,
    output logic                 BUSY_OUT,
    output logic                 DONE_OUT,
    output logic                 DROP_OUT
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic [CNT_WIDTH-1:0] g, g_nx;
    logic                 done_nx, drop_nx;
    logic                 len_ok, retrig;

    assign len_ok = (LENGTH_IN != '0);
    assign retrig = TRIG_IN && RETRIGGER && len_ok;

    // Outputs are registered from the next-state values so they line up with state.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= IDLE;
            cnt       <= '0;
            g         <= '0;
            LEVEL_OUT <= 1'b0;
            BUSY_OUT  <= 1'b0;
            DONE_OUT  <= 1'b0;
            DROP_OUT  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            g         <= g_nx;
            LEVEL_OUT <= (state_nx == HIGH);
            BUSY_OUT  <= (state_nx != IDLE);
            DONE_OUT  <= done_nx;
            DROP_OUT  <= drop_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        g_nx     = g;
        case (state)
            IDLE: begin
                if (TRIG_IN && len_ok) begin
                    state_nx = HIGH;
                    cnt_nx   = LENGTH_IN - 1'b1;
                    g_nx     = GAP_IN;
                end
            end
            HIGH: begin
                // A retrigger wins over the end-of-pulse exit in the same cycle.
                if (retrig) begin
                    cnt_nx = LENGTH_IN - 1'b1;
                    g_nx   = GAP_IN;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (g != '0) begin
                    state_nx = GAP;
                    cnt_nx   = g - 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        done_nx = (state == HIGH) && (state_nx != HIGH);
        drop_nx = 1'b0;
        if (TRIG_IN) begin
            case (state)
                IDLE:    drop_nx = !len_ok;
                HIGH:    drop_nx = !retrig;
                default: drop_nx = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: a time-based reference model checked every cycle
// for both RETRIGGER settings, plus directed scenarios with literal expectations.
module tb_pulse_stretcher;

    logic       clk;
    logic       rstn;
    logic       trig;
    logic [7:0] len;
    logic [7:0] gap;
    logic [1:0] lvl, bsy, dn, drp;

    int checks   = 0;
    int failures = 0;

    pulse_stretcher #(.CNT_WIDTH(8), .RETRIGGER(1'b0)) u_dut0 (
        .CLK(clk), .RSTN(rstn), .TRIG_IN(trig), .LENGTH_IN(len), .GAP_IN(gap),
        .LEVEL_OUT(lvl[0]), .BUSY_OUT(bsy[0]), .DONE_OUT(dn[0]), .DROP_OUT(drp[0])
    );

    pulse_stretcher #(.CNT_WIDTH(8), .RETRIGGER(1'b1)) u_dut1 (
        .CLK(clk), .RSTN(rstn), .TRIG_IN(trig), .LENGTH_IN(len), .GAP_IN(gap),
        .LEVEL_OUT(lvl[1]), .BUSY_OUT(bsy[1]), .DONE_OUT(dn[1]), .DROP_OUT(drp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the last high cycle (le) and last busy cycle (be)
    // of the current pulse as absolute cycle numbers; edge k closes cycle k.
    int   k = 0;
    int   le[2];
    int   be[2];
    bit   e_lvl[2], e_busy[2], e_done[2], e_drop[2];
    bit   mvalid = 1'b0;

    always @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (!rstn) begin
                le[r] = -100; be[r] = -100;
                e_lvl[r] = 0; e_busy[r] = 0; e_done[r] = 0; e_drop[r] = 0;
            end else begin
                e_drop[r] = 0;
                if (trig) begin
                    if (k > be[r]) begin
                        if (len != 0) begin
                            le[r] = k + int'(len);
                            be[r] = k + int'(len) + int'(gap);
                        end else e_drop[r] = 1;
                    end else if (k <= le[r]) begin
                        if (r == 1 && len != 0) begin
                            le[r] = k + int'(len);
                            be[r] = k + int'(len) + int'(gap);
                        end else e_drop[r] = 1;
                    end else e_drop[r] = 1;
                end
                e_lvl[r]  = (k + 1 <= le[r]);
                e_busy[r] = (k + 1 <= be[r]);
                e_done[r] = (k == le[r]);
            end
        end
        if (!rstn) mvalid = 1'b1;
        k++;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("model_level_r%0d", r), lvl[r], e_lvl[r]);
                chk($sformatf("model_busy_r%0d", r),  bsy[r], e_busy[r]);
                chk($sformatf("model_done_r%0d", r),  dn[r],  e_done[r]);
                chk($sformatf("model_drop_r%0d", r),  drp[r], e_drop[r]);
            end
        end
    end

    // Presents inputs for the next edge, then returns in the cycle after it.
    task automatic cyc(input logic t, input int l, input int g, input logic rn);
        trig = t; len = 8'(l); gap = 8'(g); rstn = rn;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        int  hi;
        bit  seen;
        rstn = 1'b0; trig = 1'b0; len = '0; gap = '0;
        @(negedge clk);
        cyc(1'b1, 3, 0, 1'b0);
        chk("reset_level", lvl[0], 1'b0);
        chk("reset_busy",  bsy[1], 1'b0);
        chk("reset_done",  dn[0],  1'b0);
        chk("reset_drop_ignored", drp[0] | drp[1], 1'b0);
        idle(3);

        // Basic pulse, L=3 G=0
        cyc(1'b1, 3, 0, 1'b1);
        chk("basic_c1_level", lvl[0], 1'b1);
        chk("basic_c1_busy",  bsy[0], 1'b1);
        chk("model_pin_basic_level", e_lvl[0], 1'b1);
        idle(2);
        chk("basic_c3_level", lvl[0], 1'b1);
        idle(1);
        chk("basic_c4_level", lvl[0], 1'b0);
        chk("basic_c4_done",  dn[0],  1'b1);
        chk("basic_c4_busy",  bsy[0], 1'b0);
        chk("model_pin_basic_done", e_done[0], 1'b1);
        cyc(1'b1, 3, 0, 1'b1);
        chk("basic_second_level", lvl[0], 1'b1);
        chk("basic_second_drop",  drp[0], 1'b0);
        idle(12);

        // Guard gap, L=2 G=4, trigger held high afterwards
        cyc(1'b1, 2, 4, 1'b1);
        chk("gap_c1_level", lvl[0], 1'b1);
        for (int c = 2; c <= 7; c++) begin
            cyc(1'b1, 2, 4, 1'b1);
            chk($sformatf("gap_c%0d_drop", c), drp[0], 1'b1);
            chk($sformatf("gap_c%0d_level", c), lvl[0], (c == 2) ? 1'b1 : 1'b0);
        end
        chk("gap_c7_busy", bsy[0], 1'b0);
        cyc(1'b1, 2, 4, 1'b1);
        chk("gap_c8_level", lvl[0], 1'b1);
        chk("gap_c8_drop",  drp[0], 1'b0);
        idle(16);

        // Zero length
        cyc(1'b1, 0, 3, 1'b1);
        chk("zero_drop",  drp[0], 1'b1);
        chk("zero_level", lvl[0], 1'b0);
        chk("zero_busy",  bsy[1], 1'b0);
        chk("model_pin_zero_drop", e_drop[1], 1'b1);
        idle(4);

        // Retrigger vs drop, L=4, triggers at edges 0 and 3
        cyc(1'b1, 4, 0, 1'b1);
        idle(2);
        cyc(1'b1, 4, 0, 1'b1);
        chk("retrig_c4_drop_r0", drp[0], 1'b1);
        chk("retrig_c4_drop_r1", drp[1], 1'b0);
        chk("retrig_c4_level_r1", lvl[1], 1'b1);
        idle(1);
        chk("retrig_c5_level_r0", lvl[0], 1'b0);
        chk("retrig_c5_done_r0",  dn[0],  1'b1);
        chk("retrig_c5_level_r1", lvl[1], 1'b1);
        chk("retrig_c5_done_r1",  dn[1],  1'b0);
        idle(2);
        chk("retrig_c7_level_r1", lvl[1], 1'b1);
        idle(1);
        chk("retrig_c8_level_r1", lvl[1], 1'b0);
        chk("retrig_c8_done_r1",  dn[1],  1'b1);
        idle(6);

        // Reset mid-pulse
        cyc(1'b1, 10, 0, 1'b1);
        idle(3);
        chk("rst_c4_level", lvl[0], 1'b1);
        cyc(1'b1, 10, 0, 1'b0);
        chk("rst_c5_level", lvl[0] | lvl[1], 1'b0);
        chk("rst_c5_busy",  bsy[0] | bsy[1], 1'b0);
        chk("rst_c5_done",  dn[0] | dn[1],   1'b0);
        chk("rst_c5_drop",  drp[0] | drp[1], 1'b0);
        seen = 0;
        repeat (12) begin
            cyc(1'b0, 10, 0, 1'b1);
            if (dn[0] | dn[1] | lvl[0] | lvl[1]) seen = 1;
        end
        chk("rst_no_done_after", seen, 1'b0);
        cyc(1'b1, 3, 0, 1'b1);
        chk("rst_after_accept", lvl[0], 1'b1);
        idle(8);

        // Counter extremes, L=255 G=255
        cyc(1'b1, 255, 255, 1'b1);
        hi = 0;
        repeat (254) begin
            if (lvl[0]) hi++;
            cyc(1'b0, 255, 255, 1'b1);
        end
        if (lvl[0]) hi++;
        chk("ext_high_255", (hi == 255), 1'b1);
        cyc(1'b0, 255, 255, 1'b1);
        chk("ext_c256_level", lvl[0], 1'b0);
        chk("ext_c256_done",  dn[0],  1'b1);
        chk("ext_c256_busy",  bsy[0], 1'b1);
        repeat (255) cyc(1'b1, 255, 255, 1'b1);
        chk("ext_c511_level", lvl[0], 1'b0);
        chk("ext_c511_busy",  bsy[0], 1'b0);
        chk("ext_c511_drop",  drp[0], 1'b1);
        cyc(1'b1, 255, 255, 1'b1);
        chk("ext_c512_level", lvl[0], 1'b1);
        chk("ext_c512_drop",  drp[0], 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        idle(2);

        // Randomized traffic against the model
        repeat (4000) begin
            cyc(($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 6)),
                int'($urandom_range(0, 4)),
                ($urandom_range(0, 199) != 0));
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
